// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if -- bundle of every bus signal around the arbiter.
//   req0_* / req1_* : requester beat channels (valid/we/lock/addr/wdata, ready back)
//   rd0_* / rd1_*   : per-requester read return (valid, data)
//   ram_*           : single shared RAM port (en/we/regce/addr/din out, dout in)
// slave  modport: the arbiter side.
// master modport: the side driving requests and owning the RAM.
interface bram_port_arbiter_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
);
    logic              req0_valid, req0_we, req0_lock, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_we, req1_lock, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rd0_valid, rd1_valid;
    logic [DATA_W-1:0] rd0_data, rd1_data;
    logic              ram_en, ram_we, ram_regce;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rd0_valid, rd0_data, rd1_valid, rd1_data,
        output ram_en, ram_we, ram_regce, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rd0_valid, rd0_data, rd1_valid, rd1_data,
        input  ram_en, ram_we, ram_regce, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter -- shares one BRAM port between two requesters.
// Ports:
//   clk_in : sole clock (also clocks the RAM)
//   rst_in : asynchronous active-high reset; forces all outputs to 0
//   bus    : bram_port_arbiter_if.slave (requests, read returns, RAM port)
// One beat per cycle is granted combinationally. A granted beat with lock=1
// makes its requester the owner until a lock=0 beat or LOCK_MAX beats.
// Reads are tagged into a RD_LATENCY-deep pipeline to route ram_dout back.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin IDLE arbitration;
// otherwise requester 0 has fixed priority.
module bram_port_arbiter #(
    parameter int DATA_W     = 18,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2,
    parameter int LOCK_MAX   = 256
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bram_port_arbiter_if.slave   bus
);
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_OWN0  = 2'd1;
    localparam logic [1:0]  ST_OWN1  = 2'd2;
    localparam logic [15:0] LOCK_LIM = 16'(LOCK_MAX);

    logic [1:0]             v, we, lk;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wd;

    assign v    = {bus.req1_valid, bus.req0_valid};
    assign we   = {bus.req1_we,    bus.req0_we};
    assign lk   = {bus.req1_lock,  bus.req0_lock};
    assign addr = {bus.req1_addr,  bus.req0_addr};
    assign wd   = {bus.req1_wdata, bus.req0_wdata};

    logic [1:0]            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0] id_pipe_q, id_pipe_d;
    logic [1:0]            gnt;
    logic                  xfer, gid, beat_we, beat_lock;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;  // requester favoured on an IDLE tie
`endif

    // Grant: owner-only while locked, policy-dependent in IDLE.
    always_comb begin
        gnt = '0;
        case (state_q)
            ST_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (&v) gnt = prio_q ? 2'b10 : 2'b01;
                else    gnt = v;
`else
                gnt = v[0] ? 2'b01 : {v[1], 1'b0};
`endif
            end
            ST_OWN0: gnt = {1'b0, v[0]};
            ST_OWN1: gnt = {v[1], 1'b0};
            default: gnt = '0;
        endcase
        if (rst_in) gnt = '0;
        xfer      = |gnt;
        gid       = gnt[1];
        beat_we   = we[gid];
        beat_lock = lk[gid];
    end

    // Lock FSM and burst counter. The counter includes the locking beat, so
    // release is forced on the beat that makes it equal LOCK_MAX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                if (beat_lock) begin
                    state_d = gid ? ST_OWN1 : ST_OWN0;
                    cnt_d   = 16'd1;
                end
            end else if (!beat_lock || (cnt_q + 16'd1) == LOCK_LIM) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 16'd1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        prio_d = prio_q;
        if (xfer && state_q == ST_IDLE) prio_d = ~gid;
    end
`endif

    // Read-return tag pipeline: stage 0 loads at the transfer edge, the last
    // stage lines up with ram_dout.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        id_pipe_d     = id_pipe_q;
        vld_pipe_d[0] = xfer & ~beat_we;
        id_pipe_d[0]  = gid;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            id_pipe_d[i]  = id_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            id_pipe_q  <= id_pipe_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end
`endif

    logic rv, rid;
    assign rv  = vld_pipe_q[RD_LATENCY-1];
    assign rid = id_pipe_q[RD_LATENCY-1];

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.ram_en     = xfer;
    assign bus.ram_we     = xfer & beat_we;
    assign bus.ram_addr   = xfer ? addr[gid] : '0;
    assign bus.ram_din    = xfer ? wd[gid]   : '0;
    assign bus.ram_regce  = ~rst_in;
    assign bus.rd0_valid  = rv & ~rid;
    assign bus.rd1_valid  = rv &  rid;
    assign bus.rd0_data   = (rv & ~rid) ? bus.ram_dout : '0;
    assign bus.rd1_data   = (rv &  rid) ? bus.ram_dout : '0;
endmodule
